// File: rtl/s820_misr.sv
// Multiple-input signature register compacting the 19 primary outputs of the s820 core.
// Optional golden-signature comparator enabled by defining S820_MISR_COMPARE_EN.
module s820_misr #(
  parameter int              SIG_W = 20,
  parameter logic [SIG_W-1:0] POLY = 20'h00009,
  parameter logic [SIG_W-1:0] SEED = 20'h00000,
  parameter int              CNT_W = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] N_CYC,
  input  logic             RESP_VLD,
  input  logic [18:0]      RESP,
  input  logic             ACK,
`ifdef S820_MISR_COMPARE_EN
  input  logic [SIG_W-1:0] GOLDEN,
  output logic             PASS,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [SIG_W-1:0] SIG,
  output logic [CNT_W-1:0] FOLDS
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] folds_q, folds_d;
  logic [CNT_W-1:0] ncyc_q, ncyc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  // One MISR step: shift, apply feedback when the MSB leaves, xor in the response.
  function automatic logic [SIG_W-1:0] misr_fold(input logic [SIG_W-1:0] s,
                                                 input logic [18:0]      r);
    logic [SIG_W-1:0] nxt;
    nxt = {s[SIG_W-2:0], 1'b0};
    if (s[SIG_W-1]) begin
      nxt = nxt ^ POLY;
    end else begin
      nxt = nxt;
    end
    return nxt ^ SIG_W'(r);
  endfunction

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    folds_d = folds_q;
    ncyc_d  = ncyc_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          sig_d   = SEED;
          folds_d = '0;
          pass_d  = 1'b0;
          ncyc_d  = (N_CYC == '0) ? CNT_W'(1'b1) : N_CYC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (RESP_VLD) begin
          sig_d   = misr_fold(sig_q, RESP);
          folds_d = folds_q + CNT_W'(1'b1);
          // The window closes on the edge of the final fold, not one cycle later.
          if (folds_d == ncyc_q) begin
            state_d = ST_DONE;
`ifdef S820_MISR_COMPARE_EN
            pass_d  = (sig_d == GOLDEN);
`endif
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (ACK) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      folds_q <= '0;
      ncyc_q  <= CNT_W'(1'b1);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      folds_q <= folds_d;
      ncyc_q  <= ncyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign SIG   = sig_q;
  assign FOLDS = folds_q;
`ifdef S820_MISR_COMPARE_EN
  assign PASS  = pass_q;
`else
  logic unused_pass;
  assign unused_pass = pass_q;
`endif

endmodule

// File: tb/tb_s820_misr.sv
// Self-checking bench for s820_misr: a reference MISR model pushes expected
// signature/fold-count pairs to a queue that is popped as the DUT advances.
module tb_s820_misr;

  logic        CK;
  logic        RST;
  logic        START;
  logic [15:0] N_CYC;
  logic        RESP_VLD;
  logic [18:0] RESP;
  logic        ACK;
  logic        BUSY;
  logic        DONE;
  logic [19:0] SIG;
  logic [15:0] FOLDS;
`ifdef S820_MISR_COMPARE_EN
  logic [19:0] GOLDEN;
  logic        PASS;
`endif

  typedef struct {
    logic [19:0] sig;
    logic [15:0] folds;
  } exp_t;

  exp_t        exp_q[$];
  logic        stim_vld[$];
  logic [18:0] stim_resp[$];
  int          n_checks = 0;
  int          n_errors = 0;

  s820_misr dut (
    .CK(CK), .RST(RST), .START(START), .N_CYC(N_CYC),
    .RESP_VLD(RESP_VLD), .RESP(RESP), .ACK(ACK),
`ifdef S820_MISR_COMPARE_EN
    .GOLDEN(GOLDEN), .PASS(PASS),
`endif
    .BUSY(BUSY), .DONE(DONE), .SIG(SIG), .FOLDS(FOLDS)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ref_fold(input logic [19:0] s, input logic [18:0] r);
    logic [19:0] t;
    t = s << 1;
    if (s[19]) t = t ^ 20'h00009;
    return t ^ {1'b0, r};
  endfunction

  // Run one window from IDLE with the queued stimulus; stimulus must end on the final fold.
  task automatic run_window(input logic [15:0] n);
    logic [19:0] m_sig;
    logic [15:0] m_folds;
    logic [15:0] nn;
    exp_t        e;
    nn      = (n == 16'd0) ? 16'd1 : n;
    m_sig   = 20'h00000;
    m_folds = 16'd0;
    @(negedge CK);
    START = 1'b1;
    N_CYC = n;
    @(negedge CK);
    START = 1'b0;
    N_CYC = 16'hffff;
    check("busy_after_start", BUSY, 1);
    check("sig_at_start", SIG, 20'h00000);
    check("folds_at_start", FOLDS, 0);
    for (int i = 0; i < stim_vld.size(); i++) begin
      RESP_VLD = stim_vld[i];
      RESP     = stim_resp[i];
      if (stim_vld[i] && m_folds < nn) begin
        m_sig   = ref_fold(m_sig, stim_resp[i]);
        m_folds = m_folds + 16'd1;
      end
      exp_q.push_back('{sig: m_sig, folds: m_folds});
      @(negedge CK);
      e = exp_q.pop_front();
      check("sig_step", SIG, e.sig);
      check("folds_step", FOLDS, e.folds);
    end
    RESP_VLD = 1'b0;
    RESP     = 19'h0;
    check("done_on_final_fold", DONE, 1);
    check("busy_low_in_done", BUSY, 0);
    stim_vld.delete();
    stim_resp.delete();
  endtask

  task automatic push_stim(input logic v, input logic [18:0] r);
    stim_vld.push_back(v);
    stim_resp.push_back(r);
  endtask

  task automatic do_ack(input logic [19:0] exp_sig);
    ACK = 1'b1;
    @(negedge CK);
    ACK = 1'b0;
    check("ack_to_idle_done", DONE, 0);
    check("ack_to_idle_busy", BUSY, 0);
    check("ack_sig_retained", SIG, exp_sig);
  endtask

  initial begin
    logic [18:0] r;
    int          guard;
    RST = 1'b1; START = 1'b0; N_CYC = 16'd0; RESP_VLD = 1'b0; RESP = 19'h0; ACK = 1'b0;
`ifdef S820_MISR_COMPARE_EN
    GOLDEN = 20'h00003;
`endif
    repeat (2) @(negedge CK);
    RST = 1'b0;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_sig", SIG, 20'h00000);
    check("rst_folds", FOLDS, 0);

    // Single fold.
    push_stim(1'b1, 19'h00001);
    run_window(16'd1);
    check("single_sig", SIG, 20'h00001);
    check("single_folds", FOLDS, 1);
    do_ack(20'h00001);

    // Two folds, then DONE handshake corner cases.
    push_stim(1'b1, 19'h00001);
    push_stim(1'b1, 19'h00001);
    run_window(16'd2);
    check("two_sig", SIG, 20'h00003);
`ifdef S820_MISR_COMPARE_EN
    check("pass_match", PASS, 1);
`endif
    START = 1'b1; RESP_VLD = 1'b1; RESP = 19'h7ffff;
    @(negedge CK);
    START = 1'b0; RESP_VLD = 1'b0;
    check("done_start_ignored", DONE, 1);
    check("done_sig_frozen", SIG, 20'h00003);
    check("done_folds_frozen", FOLDS, 2);
    START = 1'b1; ACK = 1'b1;
    @(negedge CK);
    START = 1'b0; ACK = 1'b0;
    check("ackstart_done", DONE, 0);
    check("ackstart_busy", BUSY, 0);
    check("ackstart_sig", SIG, 20'h00003);
    @(negedge CK);
    check("ackstart_no_restart", BUSY, 0);
`ifdef S820_MISR_COMPARE_EN
    check("pass_held_idle", PASS, 1);
    GOLDEN = 20'h00004;
`endif

    // Feedback wrap: bit 18 walks to the MSB, then folds back through the polynomial.
    push_stim(1'b1, 19'h40000);
    push_stim(1'b1, 19'h00000);
    push_stim(1'b1, 19'h00000);
`ifdef S820_MISR_COMPARE_EN
    @(negedge CK);
    START = 1'b1; N_CYC = 16'd3;
    @(negedge CK);
    START = 1'b0;
    check("pass_cleared_on_start", PASS, 0);
    RESP_VLD = 1'b1; RESP = 19'h40000; @(negedge CK);
    RESP = 19'h0; @(negedge CK); @(negedge CK);
    RESP_VLD = 1'b0;
    check("wrap_sig_cmp", SIG, 20'h00009);
    check("pass_mismatch", PASS, 0);
    stim_vld.delete(); stim_resp.delete();
`else
    run_window(16'd3);
`endif
    check("wrap_sig", SIG, 20'h00009);
    do_ack(20'h00009);

    // Gaps: 1,0,0,1,1 with three folds.
    push_stim(1'b1, 19'h12345);
    push_stim(1'b0, 19'h7ffff);
    push_stim(1'b0, 19'h55555);
    push_stim(1'b1, 19'h0abcd);
    push_stim(1'b1, 19'h3c3c3);
    run_window(16'd3);
    check("gap_folds", FOLDS, 3);
    do_ack(ref_fold(ref_fold(ref_fold(20'h0, 19'h12345), 19'h0abcd), 19'h3c3c3));

    // N_CYC of zero behaves as one.
    push_stim(1'b1, 19'h2aaaa);
    run_window(16'd0);
    check("ncyc0_folds", FOLDS, 1);
    do_ack(20'h2aaaa);

    // Random windows with random gaps.
    for (int w = 0; w < 4; w++) begin
      int n, got;
      n   = $urandom_range(2, 9);
      got = 0;
      while (got < n) begin
        r = 19'($urandom);
        if ($urandom_range(0, 3) != 0 || got == n - 1) begin
          push_stim(1'b1, r);
          got++;
        end else begin
          push_stim(1'b0, r);
        end
      end
      run_window(16'(n));
      check("rand_folds", FOLDS, n);
      ACK = 1'b1; @(negedge CK); ACK = 1'b0;
    end

    // Reset mid-window after two of four folds.
    @(negedge CK);
    START = 1'b1; N_CYC = 16'd4;
    @(negedge CK);
    START = 1'b0; ACK = 1'b1;
    RESP_VLD = 1'b1; RESP = 19'h11111; @(negedge CK);
    RESP = 19'h22222; @(negedge CK);
    ACK = 1'b0;
    check("mid_busy", BUSY, 1);
    check("mid_folds", FOLDS, 2);
    RESP_VLD = 1'b0; RST = 1'b1; START = 1'b1;
    @(negedge CK);
    RST = 1'b0; START = 1'b0;
    check("midrst_busy", BUSY, 0);
    check("midrst_done", DONE, 0);
    check("midrst_sig", SIG, 20'h00000);
    check("midrst_folds", FOLDS, 0);

    // DONE must not appear without further folds; bounded wait.
    guard = 0;
    while (!DONE && guard < 10) begin
      @(negedge CK);
      guard++;
    end
    check("no_spurious_done", DONE, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
